// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller slice.
package atm_pkg;

  // Session states; the encoding is also what state_o shows on the debug/display port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PIN_WAIT  = 3'd1,
    ST_PIN_CHECK = 3'd2,
    ST_MENU      = 3'd3,
    ST_TXN_BUSY  = 3'd4,
    ST_EJECT     = 3'd5,
    ST_RETAIN    = 3'd6
  } state_t;

  // Menu selections carried on op_code / txn_op.
  localparam logic [1:0] OP_BAL  = 2'd0;
  localparam logic [1:0] OP_WDR  = 2'd1;
  localparam logic [1:0] OP_DEP  = 2'd2;
  localparam logic [1:0] OP_EXIT = 2'd3;

  // Production defaults: 1 MHz clock, 30 s of inactivity ends a session.
  localparam int unsigned DEF_CLK_FREQ    = 1000000;
  localparam int unsigned DEF_TIMEOUT_SEC = 30;

endpackage

// File: rtl/session_timer.sv
// Inactivity timer: counts enabled cycles, strobes timeout on the TC-th one
// after a restart, then wraps. Count holds whenever en is low.
module session_timer #(
  parameter int unsigned CLK_FREQ    = atm_pkg::DEF_CLK_FREQ,
  parameter int unsigned TIMEOUT_SEC = atm_pkg::DEF_TIMEOUT_SEC
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic timeout
);

  localparam logic [31:0] TC      = CLK_FREQ * TIMEOUT_SEC;
  localparam logic [31:0] TC_LAST = TC - 32'd1;

  logic [31:0] count_q;
  logic [31:0] count_d;

  // A restart in the same cycle masks the strobe: the session just saw activity.
  assign timeout = en && !restart && (count_q == TC_LAST);

  // Next count: restart clears, enabled cycles advance and wrap on timeout.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (en) begin
      count_d = timeout ? '0 : count_q + 32'd1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Card session sequencer: card insert, PIN entry with retry limit, menu,
// datapath transaction handshake, and inactivity abort via session_timer.
//
// Datapath handshake: txn_req rises the cycle after a menu selection and stays
// high (with txn_op stable) until the cycle after the one-cycle txn_ack pulse;
// txn_ok is sampled only together with txn_ack, and acks seen while no request
// is outstanding are ignored.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
  parameter int unsigned TIMEOUT_SEC = DEF_TIMEOUT_SEC,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned PIN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic [PIN_W-1:0] card_pin,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_entry,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             txn_ack,
  input  logic             txn_ok,
  output logic             txn_req,
  output logic [1:0]       txn_op,
  output logic             pin_error,
  output logic             eject_card,
  output logic             card_retained,
  output logic             session_timeout,
  output logic             last_txn_ok,
  output logic [2:0]       state_o
);

  localparam logic [2:0] TRIES_LIMIT = 3'(MAX_TRIES);

  state_t           state_q, state_d;
  logic [2:0]       tries_q, tries_d;
  logic [2:0]       tries_inc;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic [1:0]       txn_op_q, txn_op_d;
  logic             last_ok_q, last_ok_d;
  logic             pin_error_q, pin_error_d;
  logic             timeout_q, timeout_d;
  logic             txn_req_q, eject_q, retain_q;

  logic tmr_en;
  logic tmr_restart;
  logic tmr_timeout;

  // The timer only runs while the session waits on the customer.
  assign tmr_en    = (state_q == ST_PIN_WAIT) || (state_q == ST_MENU);
  assign tries_inc = tries_q + 3'd1;

  session_timer #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (tmr_en),
    .restart(tmr_restart),
    .timeout(tmr_timeout)
  );

  // Next-state, latches and one-cycle pulse requests; card removal beats any strobe.
  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    pin_d       = pin_q;
    txn_op_d    = txn_op_q;
    last_ok_d   = last_ok_q;
    pin_error_d = 1'b0;
    timeout_d   = 1'b0;
    tmr_restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (card_in) begin
          state_d     = ST_PIN_WAIT;
          tries_d     = '0;
          tmr_restart = 1'b1;
        end
      end
      ST_PIN_WAIT: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end else if (pin_valid) begin
          pin_d   = pin_entry;
          state_d = ST_PIN_CHECK;
        end else if (tmr_timeout) begin
          timeout_d = 1'b1;
          state_d   = ST_EJECT;
        end
      end
      ST_PIN_CHECK: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end else if (pin_q == card_pin) begin
          state_d     = ST_MENU;
          tmr_restart = 1'b1;
        end else begin
          pin_error_d = 1'b1;
          tries_d     = tries_inc;
          if (tries_inc == TRIES_LIMIT) begin
            state_d = ST_RETAIN;
          end else begin
            state_d     = ST_PIN_WAIT;
            tmr_restart = 1'b1;
          end
        end
      end
      ST_MENU: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end else if (op_valid) begin
          if (op_code == OP_EXIT) begin
            state_d = ST_EJECT;
          end else begin
            txn_op_d = op_code;
            state_d  = ST_TXN_BUSY;
          end
        end else if (tmr_timeout) begin
          timeout_d = 1'b1;
          state_d   = ST_EJECT;
        end
      end
      ST_TXN_BUSY: begin
        // No datapath timeout: the account side always answers eventually.
        if (txn_ack) begin
          last_ok_d   = txn_ok;
          tmr_restart = 1'b1;
          state_d     = card_in ? ST_MENU : ST_IDLE;
        end
      end
      ST_EJECT, ST_RETAIN: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Session state, retry count and latched operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tries_q   <= '0;
      pin_q     <= '0;
      txn_op_q  <= '0;
      last_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      pin_q     <= pin_d;
      txn_op_q  <= txn_op_d;
      last_ok_q <= last_ok_d;
    end
  end

  // Registered outputs: levels follow the state being entered, pulses last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_req_q   <= 1'b0;
      eject_q     <= 1'b0;
      retain_q    <= 1'b0;
      pin_error_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      txn_req_q   <= (state_d == ST_TXN_BUSY);
      eject_q     <= (state_d == ST_EJECT);
      retain_q    <= (state_d == ST_RETAIN);
      pin_error_q <= pin_error_d;
      timeout_q   <= timeout_d;
    end
  end

  assign txn_req         = txn_req_q;
  assign txn_op          = txn_op_q;
  assign pin_error       = pin_error_q;
  assign eject_card      = eject_q;
  assign card_retained   = retain_q;
  assign session_timeout = timeout_q;
  assign last_txn_ok     = last_ok_q;
  assign state_o         = state_q;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Session-level controller for the ATM. Sequences a card session: card insert, PIN entry with a retry limit, transaction menu, and a datapath transaction handshake. Owns and sequences the inactivity timer: it restarts, pauses and observes the timer to abort idle sessions. Sits between the card/keypad front end and the account datapath.

Parameters:
CLK_FREQ, 1000000, clock cycles per second
TIMEOUT_SEC, 30, inactivity timeout in seconds; terminal count TC = CLK_FREQ*TIMEOUT_SEC (32-bit)
MAX_TRIES, 3, PIN mismatches before the card is retained (2..7)
PIN_W, 16, PIN width (4 BCD digits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
card_in  in  1  card present in slot (level, synchronous to clk)
card_pin  in  PIN_W  PIN stored on card, stable while card_in=1
pin_valid  in  1  one-cycle strobe: pin_entry holds a keyed PIN
pin_entry  in  PIN_W  keyed PIN
op_valid  in  1  one-cycle strobe: op_code holds a menu selection
op_code  in  2  0=balance, 1=withdraw, 2=deposit, 3=exit
txn_ack  in  1  datapath done, one-cycle pulse
txn_ok  in  1  datapath result, sampled with txn_ack
txn_req  out  1  transaction request, held until txn_ack
txn_op  out  2  latched op_code, stable while txn_req=1
pin_error  out  1  one-cycle pulse on a PIN mismatch
eject_card  out  1  level: eject card
card_retained  out  1  level: card captured
session_timeout  out  1  one-cycle pulse when the session aborts on inactivity
last_txn_ok  out  1  txn_ok latched at the last txn_ack
state_o  out  3  current state encoding, for debug and display

Behaviour:
- Reset: state IDLE, tries=0, timer count=0. All outputs 0.
- States: IDLE, PIN_WAIT, PIN_CHECK, MENU, TXN_BUSY, EJECT, RETAIN.
- IDLE: card_in=1 -> PIN_WAIT; tries<=0; timer restart.
- PIN_WAIT: pin_valid -> latch pin_entry, go to PIN_CHECK.
  - Else timer timeout -> session_timeout pulse, go to EJECT.
  - pin_valid and timeout in the same cycle: pin_valid wins, no pulse.
- PIN_CHECK (exactly 1 cycle):
  - Match with card_pin -> MENU, timer restart.
  - Mismatch: pin_error pulse; tries+1. If tries+1==MAX_TRIES -> RETAIN, else PIN_WAIT with timer restart.
- MENU: op_valid with op 3 -> EJECT.
  - op_valid with op 0..2 -> latch txn_op, assert txn_req next cycle, go to TXN_BUSY.
  - Else timeout -> session_timeout pulse, go to EJECT.
  - op_valid and timeout in the same cycle: op_valid wins.
- TXN_BUSY: txn_req=1 and the timer is paused (count held).
  - txn_ack -> txn_req=0 next cycle, last_txn_ok<=txn_ok, timer restart, go to MENU.
  - No datapath timeout.
- EJECT: eject_card=1 until card_in=0, then IDLE.
- RETAIN: card_retained=1 until card_in=0, then IDLE.
- card_in=0 in PIN_WAIT, PIN_CHECK or MENU: go directly to IDLE, no pulses.
- card_in=0 in TXN_BUSY: stay until txn_ack, then go to IDLE instead of MENU.
- Timer:
  - Enabled only in PIN_WAIT and MENU; count held in other states.
  - Restart clears count to 0 in the same edge. Restart has priority over increment and timeout.
  - Timeout is a combinational strobe when count==TC-1 and enabled. Count then wraps to 0.
  - First timeout comes exactly TC enabled cycles after a restart.
- Strobes ignored outside their state: pin_valid outside PIN_WAIT, op_valid outside MENU, txn_ack outside TXN_BUSY.
- All outputs registered except state_o decode. Outputs change on clk edge after the causing input.
- rst mid-session: immediate return to the reset state. txn_req drops asynchronously.

Decomposition:
- Package atm_pkg:
  - state enum (3-bit)
  - op_code constants OP_BAL/OP_WDR/OP_DEP/OP_EXIT
  - default CLK_FREQ and TIMEOUT_SEC
- Sub-module session_timer: parameters CLK_FREQ and TIMEOUT_SEC; ports clk, rst, en, restart, timeout. Generalises the existing free-running timeout counter with enable and restart.
- FSM, tries counter and PIN compare live in atm_session_ctrl.

Test Plan:
Bench uses CLK_FREQ=10, TIMEOUT_SEC=2 (TC=20), MAX_TRIES=3, card_pin=16'h1234.
1. Good path: card_in=1, pin 16'h1234, op 1, txn_ack with txn_ok=1 two cycles after txn_req, then op 3 -> txn_req/txn_op=1, then last_txn_ok=1, eject_card=1. card_in=0 -> IDLE.
2. Three wrong PINs (16'h1111) -> three pin_error pulses, card_retained=1 after the third, no MENU entry.
3. Two wrong PINs then correct -> two pin_error pulses, then MENU; tries cleared on the next card.
4. No input in MENU -> session_timeout exactly 20 cycles after entry, then eject_card. Same with op_valid at cycle 19: no timeout, transaction proceeds.
5. Inactivity with a 50-cycle txn_ack delay -> no timeout during TXN_BUSY; full 20 cycles counted afresh after return to MENU.
6. rst asserted while txn_req=1 -> txn_req=0 and state IDLE immediately. card_in=0 during TXN_BUSY, then txn_ack -> IDLE, no eject.
